gray_to_binary_converter: RTL and testbench



---
 rtl/gray_to_binary_converter.sv | 87 ++++++++
 tb/tb_gray_to_binary_converter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gray_to_binary_converter.sv
// Registered Gray-to-binary converter with a valid-qualified pipeline and a
// monitor that flags input steps changing more than one bit.
module gray_to_binary_converter #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] binary_out,
  output logic             step_error
);

  logic [WIDTH-1:0]   conv;
  logic [WIDTH-1:0]   diff;
  logic               step_bad;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               has_prev_q, has_prev_d;
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [WIDTH-1:0]   data_d [LATENCY];

  always_comb begin
    conv = '0;
    conv[WIDTH-1] = gray_in[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      conv[k] = conv[k+1] ^ gray_in[k];
    end
  end

  // diff & (diff-1) is nonzero exactly when more than one bit differs.
  assign diff     = gray_in ^ prev_q;
  assign step_bad = has_prev_q && ((diff & (diff - WIDTH'(1))) != '0);

  always_comb begin
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    valid_d    = '0;
    err_d      = err_q;
    data_d     = data_q;

    valid_d[0] = in_valid;
    if (in_valid) begin
      data_d[0]  = conv;
      err_d[0]   = step_bad;
      prev_d     = gray_in;
      has_prev_d = 1'b1;
    end

    // Later stages only load payload when the valid arriving from upstream is set.
    for (int s = 1; s < LATENCY; s++) begin
      valid_d[s] = valid_q[s-1];
      if (valid_q[s-1]) begin
        data_d[s] = data_q[s-1];
        err_d[s]  = err_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      has_prev_q <= 1'b0;
      valid_q    <= '0;
      err_q      <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      prev_q     <= prev_d;
      has_prev_q <= has_prev_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      for (int s = 0; s < LATENCY; s++) begin
        data_q[s] <= data_d[s];
      end
    end
  end

  assign out_valid  = valid_q[LATENCY-1];
  assign binary_out = data_q[LATENCY-1];
  assign step_error = valid_q[LATENCY-1] & err_q[LATENCY-1];

endmodule

// File: tb/tb_gray_to_binary_converter.sv
// Self-checking bench: four converter configurations driven in lockstep and
// compared each cycle against a delay-line reference model.
module tb_gray_to_binary_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  gray4;
  logic [15:0] gray16;

  logic        ov [1:3];
  logic [3:0]  bo [1:3];
  logic        se [1:3];
  logic        ov16;
  logic [15:0] bo16;
  logic        se16;

  int total = 0;
  int bad   = 0;

  logic        hist_v   [4];
  logic [15:0] hist_b4  [4];
  logic        hist_e4  [4];
  logic [15:0] hist_b16 [4];
  logic        hist_e16 [4];
  logic [15:0] held4    [1:3];
  logic [15:0] held16;
  logic [15:0] prev4, prev16;
  logic        has_prev;

  always #5 clk = ~clk;

  gray_to_binary_converter #(.WIDTH(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray4),
    .out_valid(ov[1]), .binary_out(bo[1]), .step_error(se[1]));
  gray_to_binary_converter #(.WIDTH(4), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray4),
    .out_valid(ov[2]), .binary_out(bo[2]), .step_error(se[2]));
  gray_to_binary_converter #(.WIDTH(4), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray4),
    .out_valid(ov[3]), .binary_out(bo[3]), .step_error(se[3]));
  gray_to_binary_converter #(.WIDTH(16), .LATENCY(2)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray16),
    .out_valid(ov16), .binary_out(bo16), .step_error(se16));

  // binary[k] is the XOR of all Gray bits at or above k.
  function automatic logic [15:0] ref_conv(input logic [15:0] g, input int w);
    logic [15:0] r = '0;
    for (int k = 0; k < w; k++) r[k] = ^(g >> k);
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int k = 0; k < 4; k++) hist_v[k] = 1'b0;
      for (int l = 1; l <= 3; l++) held4[l] = '0;
      held16   = '0;
      prev4    = '0;
      prev16   = '0;
      has_prev = 1'b0;
    end else begin
      for (int k = 3; k >= 1; k--) begin
        hist_v[k]   = hist_v[k-1];
        hist_b4[k]  = hist_b4[k-1];
        hist_e4[k]  = hist_e4[k-1];
        hist_b16[k] = hist_b16[k-1];
        hist_e16[k] = hist_e16[k-1];
      end
      hist_v[0] = in_valid;
      if (in_valid) begin
        hist_b4[0]  = ref_conv({12'h0, gray4}, 4);
        hist_e4[0]  = has_prev && ($countones({12'h0, gray4} ^ prev4) > 1);
        hist_b16[0] = ref_conv(gray16, 16);
        hist_e16[0] = has_prev && ($countones(gray16 ^ prev16) > 1);
        prev4       = {12'h0, gray4};
        prev16      = gray16;
        has_prev    = 1'b1;
      end
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic v, input logic [3:0] g, input logic [15:0] w);
    rst      = r;
    in_valid = v;
    gray4    = g;
    gray16   = w;
    @(posedge clk);
    model_edge();
    #1;
    for (int l = 1; l <= 3; l++) begin
      if (hist_v[l-1]) held4[l] = hist_b4[l-1];
      check_output($sformatf("l%0d_valid", l), {31'h0, ov[l]}, {31'h0, hist_v[l-1]});
      check_output($sformatf("l%0d_bin", l), {28'h0, bo[l]}, {16'h0, held4[l]});
      check_output($sformatf("l%0d_err", l), {31'h0, se[l]}, {31'h0, hist_v[l-1] & hist_e4[l-1]});
    end
    if (hist_v[1]) held16 = hist_b16[1];
    check_output("w16_valid", {31'h0, ov16}, {31'h0, hist_v[1]});
    check_output("w16_bin", {16'h0, bo16}, {16'h0, held16});
    check_output("w16_err", {31'h0, se16}, {31'h0, hist_v[1] & hist_e16[1]});
  endtask

  initial begin
    logic [3:0] g;
    rst = 1'b1; in_valid = 1'b0; gray4 = '0; gray16 = '0;
    for (int k = 0; k < 4; k++) begin
      hist_v[k] = 1'b0; hist_b4[k] = '0; hist_e4[k] = 1'b0;
      hist_b16[k] = '0; hist_e16[k] = 1'b0;
    end
    apply_stimulus(1'b1, 1'b1, 4'hF, 16'hFFFF);
    apply_stimulus(1'b1, 1'b0, 4'h0, 16'h0);
    check_output("reset_valid", {31'h0, ov[1]}, 32'h0);
    check_output("reset_bin", {28'h0, bo[3]}, 32'h0);

    // Full Gray sweep: binary comes back as the plain count.
    for (int i = 0; i < 16; i++) begin
      g = 4'(i ^ (i >> 1));
      apply_stimulus(1'b0, 1'b1, g, {12'h0, g});
      check_output("sweep_bin", {28'h0, bo[1]}, i);
      check_output("sweep_err", {31'h0, se[1]}, 32'h0);
    end

    apply_stimulus(1'b0, 1'b1, 4'b0000, 16'h0);
    check_output("viol_first_bin", {28'h0, bo[1]}, 32'h0);
    apply_stimulus(1'b0, 1'b1, 4'b0011, 16'h3);
    check_output("viol_bin", {28'h0, bo[1]}, 32'h2);
    check_output("viol_err", {31'h0, se[1]}, 32'h1);
    apply_stimulus(1'b0, 1'b1, 4'b0010, 16'h2);
    check_output("single_step_err", {31'h0, se[1]}, 32'h0);

    // Reset with samples still inside the three-stage pipeline.
    apply_stimulus(1'b0, 1'b1, 4'h5, 16'h5);
    apply_stimulus(1'b0, 1'b1, 4'h6, 16'h6);
    apply_stimulus(1'b1, 1'b1, 4'h7, 16'h7);
    check_output("mid_reset_valid", {31'h0, ov[3]}, 32'h0);
    check_output("mid_reset_bin", {28'h0, bo[3]}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 4'h0, 16'h0);
      check_output("flushed_valid", {31'h0, ov[3]}, 32'h0);
    end
    apply_stimulus(1'b0, 1'b1, 4'b1111, 16'hF);
    check_output("post_reset_bin", {28'h0, bo[1]}, 32'hA);
    check_output("post_reset_err", {31'h0, se[1]}, 32'h0);

    // Gapped input seen through the two-stage pipeline.
    apply_stimulus(1'b0, 1'b1, 4'b0001, 16'h1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 4'h0, 16'h0);
    check_output("gap_hold_bin", {28'h0, bo[2]}, 32'h1);
    check_output("gap_hold_valid", {31'h0, ov[2]}, 32'h0);
    check_output("gap_hold_err", {31'h0, se[2]}, 32'h0);
    apply_stimulus(1'b0, 1'b1, 4'b0011, 16'h3);
    check_output("gap_latency_valid", {31'h0, ov[2]}, 32'h0);
    apply_stimulus(1'b0, 1'b0, 4'h0, 16'h0);
    check_output("gap_bin", {28'h0, bo[2]}, 32'h2);
    check_output("gap_err", {31'h0, se[2]}, 32'h0);

    apply_stimulus(1'b0, 1'b1, 4'h0, 16'h8000);
    apply_stimulus(1'b0, 1'b1, 4'h0, 16'hC000);
    check_output("wide_8000", {16'h0, bo16}, 32'hFFFF);
    apply_stimulus(1'b0, 1'b1, 4'h0, 16'h0001);
    check_output("wide_c000", {16'h0, bo16}, 32'h8000);
    apply_stimulus(1'b0, 1'b0, 4'h0, 16'h0);
    check_output("wide_0001", {16'h0, bo16}, 32'h0001);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                     4'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
